// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
// Build option: define PARITY_CHECK_EN to add the even-parity PARITY state.
package serial_rx_pkg;

    localparam int DEFAULT_WIDTH = 4;

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;
`endif

endpackage

// File: rtl/sipo_shift_reg.sv
// MSB-first serial-in/parallel-out shift register with a first-bit load.
// next_word exposes the value the register takes on the coming edge.
module sipo_shift_reg
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic             load,
    input  logic             Din,
    output logic [WIDTH-1:0] next_word
);

    logic [WIDTH-1:0] sr;

    // NOTE: the default assignment first keeps this block latch-free.
    always_comb begin
        next_word = sr;
        if (shift_en) begin
            next_word = load ? {{(WIDTH-1){1'b0}}, Din} : {sr[WIDTH-2:0], Din};
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge Clk) begin
        if (reset) begin
            sr <= '0;
        end else begin
            sr <= next_word;
        end
    end

endmodule

// File: rtl/serial_to_parallel_receiver.sv
// Serial-to-parallel receiver: bit counter, FSM and handshake flags around sipo_shift_reg.
// Build option: PARITY_CHECK_EN appends an even-parity bit to each word.
module serial_to_parallel_receiver
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             Din,
    input  logic             shift_en,
    input  logic             ack,
    output logic [WIDTH-1:0] Q,
    output logic             valid,
    output logic             busy,
    output logic             overrun
`ifdef PARITY_CHECK_EN
    ,
    output logic             parity_err
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] next_word;
    logic             sr_shift;

`ifdef PARITY_CHECK_EN
    // The parity bit is checked, never stored, so the data stays put in PARITY.
    assign sr_shift = shift_en && (state != PARITY);
`else
    assign sr_shift = shift_en;
`endif

    sipo_shift_reg #(.WIDTH(WIDTH)) u_sipo (
        .Clk      (Clk),
        .reset    (reset),
        .shift_en (sr_shift),
        .load     (state == IDLE),
        .Din      (Din),
        .next_word(next_word)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            Q       <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
        end else begin
`ifdef PARITY_CHECK_EN
            parity_err <= 1'b0;
`endif
            // A completing word below overrides this clear (last assignment wins).
            if (ack && valid) begin
                valid <= 1'b0;
            end
            if (shift_en) begin
                case (state)
                    IDLE: begin
                        count <= CNT_W'(1);
                        state <= DATA;
                    end
                    DATA: begin
                        if (count == LAST_DATA) begin
                            count <= '0;
`ifdef PARITY_CHECK_EN
                            state <= PARITY;
`else
                            state <= IDLE;
                            Q     <= next_word;
                            valid <= 1'b1;
                            if (valid && !ack) begin
                                overrun <= 1'b1;
                            end
`endif
                        end else begin
                            count <= count + CNT_W'(1);
                        end
                    end
`ifdef PARITY_CHECK_EN
                    PARITY: begin
                        state <= IDLE;
                        if ((^next_word) ^ Din) begin
                            parity_err <= 1'b1;
                        end else begin
                            Q     <= next_word;
                            valid <= 1'b1;
                            if (valid && !ack) begin
                                overrun <= 1'b1;
                            end
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_to_parallel_receiver.sv
// Self-checking bench for serial_to_parallel_receiver at WIDTH=4.
// Define PARITY_CHECK_EN for both bench and RTL to exercise the parity build.
module tb_serial_to_parallel_receiver;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       Din = 1'b0;
    logic       shift_en = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] Q;
    logic       valid;
    logic       busy;
    logic       overrun;
`ifdef PARITY_CHECK_EN
    logic       parity_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    serial_to_parallel_receiver #(.WIDTH(4)) dut (
        .Clk      (Clk),
        .reset    (reset),
        .Din      (Din),
        .shift_en (shift_en),
        .ack      (ack),
        .Q        (Q),
        .valid    (valid),
        .busy     (busy),
        .overrun  (overrun)
`ifdef PARITY_CHECK_EN
        ,
        .parity_err(parity_err)
`endif
    );

    typedef struct {
        logic       rst;
        logic       se;
        logic       din;
        logic       ak;
        logic [3:0] q;
        logic       v;
        logic       b;
        logic       o;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic se, logic din, logic ak,
                                logic [3:0] q, logic v, logic b, logic o);
        vec_t r;
        r.rst = rst; r.se = se; r.din = din; r.ak = ak;
        r.q = q; r.v = v; r.b = b; r.o = o;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one edge's inputs on the falling edge, then samples just after the rising edge.
    task automatic step(input logic rst, input logic se, input logic din, input logic ak);
        @(negedge Clk);
        reset = rst; shift_en = se; Din = din; ack = ak;
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] outs(logic [3:0] q, logic v, logic b, logic o);
        return {25'd0, q, v, b, o};
    endfunction

    task automatic send_word(input logic [3:0] w, input logic ack_last);
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 1'b1, w[i], (i == 0) ? ack_last : 1'b0);
        end
    endtask

    initial begin
`ifndef PARITY_CHECK_EN
        // Reset state, with reset asserted over active shift_en/ack.
        vecs.push_back(mk(1, 1, 1, 1, 4'b0000, 0, 0, 0));
        // 1,0,1,1 back to back
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b1011, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'b1011, 0, 0, 0));
        // 1,1 then a 3-cycle stall with Din toggling, then 0,0
        vecs.push_back(mk(0, 1, 1, 0, 4'b1011, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b1011, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'b1011, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 4'b1011, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 4'b1011, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b1011, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b1100, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'b1100, 0, 0, 0));
        // 0101 then 0011 with no ack: overrun
        vecs.push_back(mk(0, 1, 0, 0, 4'b1100, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b1100, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b1100, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0101, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0101, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0101, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0101, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0011, 1, 0, 1));
        // Same pair with ack on word 2's completing edge: no overrun
        vecs.push_back(mk(1, 1, 1, 1, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0101, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0101, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0101, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0101, 1, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 4'b0011, 1, 0, 0));
        // ack clears valid; ack with valid low changes nothing
        vecs.push_back(mk(0, 0, 0, 1, 4'b0011, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 4'b0011, 0, 0, 0));
        // Reset mid-word discards it; 1111 afterwards has no residue
        vecs.push_back(mk(0, 1, 1, 0, 4'b0011, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 4'b0011, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 0, 4'b1111, 1, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].se, vecs[i].din, vecs[i].ak);
            check($sformatf("vec%0d {q,v,b,o}", i), outs(Q, valid, busy, overrun),
                  outs(vecs[i].q, vecs[i].v, vecs[i].b, vecs[i].o));
        end

        // Overrun is sticky through ack and later clean words.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(4'b0101, 1'b0);
        send_word(4'b0011, 1'b0);
        check("seq overrun set", outs(Q, valid, busy, overrun), outs(4'b0011, 1, 0, 1));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("seq ack keeps overrun", outs(Q, valid, busy, overrun), outs(4'b0011, 0, 0, 1));
        send_word(4'b1001, 1'b0);
        check("seq overrun sticky", outs(Q, valid, busy, overrun), outs(4'b1001, 1, 0, 1));
        // Three words streamed with shift_en held and ack on every completion.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(4'b1110, 1'b1);
        check("stream w1", outs(Q, valid, busy, overrun), outs(4'b1110, 1, 0, 0));
        send_word(4'b0111, 1'b1);
        check("stream w2", outs(Q, valid, busy, overrun), outs(4'b0111, 1, 0, 0));
        send_word(4'b1000, 1'b1);
        check("stream w3", outs(Q, valid, busy, overrun), outs(4'b1000, 1, 0, 0));
`else
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("par reset", {outs(Q, valid, busy, overrun), parity_err}, {outs(4'b0000, 0, 0, 0), 1'b0});
        // Good word first so Q/valid are non-trivial when the bad one arrives.
        send_word(4'b0110, 1'b0);
        check("par data done busy", outs(Q, valid, busy, overrun), outs(4'b0000, 0, 1, 0));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("par good word", {outs(Q, valid, busy, overrun), parity_err}, {outs(4'b0110, 1, 0, 0), 1'b0});
        send_word(4'b1011, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("par bad word", {outs(Q, valid, busy, overrun), parity_err}, {outs(4'b0110, 1, 0, 0), 1'b1});
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("par err one cycle", {outs(Q, valid, busy, overrun), parity_err}, {outs(4'b0110, 1, 0, 0), 1'b0});
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(4'b1011, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("par resend", {outs(Q, valid, busy, overrun), parity_err}, {outs(4'b1011, 1, 0, 0), 1'b0});
        send_word(4'b0011, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("par overrun", {outs(Q, valid, busy, overrun), parity_err}, {outs(4'b0011, 1, 0, 1), 1'b0});
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
